// File: rtl/press_pkg.sv
// State encoding shared by the press decoder and its bench-visible width.
package press_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    D_Idle  = 2'd0,
    D_Wait1 = 2'd1,
    D_Wait2 = 2'd2
  } state_e;
endpackage

// File: rtl/gap_timer.sv
// Gesture window timer: cleared on each accepted press, counts while a gesture is open.
module gap_timer #(
  parameter int GAP = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(GAP + 1);

  logic [W-1:0] tmr_q, tmr_d;

  always_comb begin
    tmr_d = tmr_q;
    if (clr) begin
      tmr_d = '0;
    end else if (en) begin
      tmr_d = tmr_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

  // Flags the edge on which the count reaches GAP, so the strobe registers at offset GAP.
  assign expired = en && !clr && (tmr_q == W'(GAP - 1));
endmodule

// File: rtl/press_decoder.sv
// Classifies press pulses into single/double (and triple with PRESS_DECODER_TRIPLE_EN) gestures.
module press_decoder
  import press_pkg::*;
#(
  parameter int GAP   = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p,
  output logic             single,
  output logic             double,
  output logic             triple,
  output logic             busy,
  output logic [CNT_W-1:0] evt_cnt
);
  state_e           state_q, state_d;
  logic             single_q, single_d;
  logic             double_q, double_d;
  logic             triple_q, triple_d;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmr_clr, tmr_en, tmr_expired;

  gap_timer #(.GAP(GAP)) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  assign tmr_en = (state_q != D_Idle);

  always_comb begin
    state_d  = state_q;
    single_d = 1'b0;
    double_d = 1'b0;
    triple_d = 1'b0;
    tmr_clr  = 1'b0;
    case (state_q)
      D_Idle: begin
        if (p) begin
          state_d = D_Wait1;
          tmr_clr = 1'b1;
        end
      end
      D_Wait1: begin
        // A pulse on the expiry edge is checked first so it extends the gesture.
        if (p) begin
`ifdef PRESS_DECODER_TRIPLE_EN
          state_d = D_Wait2;
          tmr_clr = 1'b1;
`else
          double_d = 1'b1;
          state_d  = D_Idle;
`endif
        end else if (tmr_expired) begin
          single_d = 1'b1;
          state_d  = D_Idle;
        end
      end
`ifdef PRESS_DECODER_TRIPLE_EN
      D_Wait2: begin
        if (p) begin
          triple_d = 1'b1;
          state_d  = D_Idle;
        end else if (tmr_expired) begin
          double_d = 1'b1;
          state_d  = D_Idle;
        end
      end
`endif
      default: state_d = D_Idle;
    endcase
    cnt_d = cnt_q + CNT_W'(single_d | double_d | triple_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= D_Idle;
      single_q <= 1'b0;
      double_q <= 1'b0;
      triple_q <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      single_q <= single_d;
      double_q <= double_d;
      triple_q <= triple_d;
      busy_q   <= (state_d != D_Idle);
      cnt_q    <= cnt_d;
    end
  end

  assign single  = single_q;
  assign double  = double_q;
  assign triple  = triple_q;
  assign busy    = busy_q;
  assign evt_cnt = cnt_q;
endmodule

// File: tb/tb_press_decoder.sv
// Randomized and directed checks of press_decoder against a gesture-level reference model.
module tb_press_decoder;
  localparam int GAP   = 8;
  localparam int CNT_W = 2;
`ifdef PRESS_DECODER_TRIPLE_EN
  localparam int MAXN = 3;
`else
  localparam int MAXN = 2;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             p   = 1'b0;
  logic             single, double, triple, busy;
  logic [CNT_W-1:0] evt_cnt;

  int checks = 0;
  int errors = 0;

  // Gesture-level model: presses collected so far and the time of the last one.
  int   m_n = 0, m_last = 0, m_t = 0, m_cnt = 0;
  logic m_single = 0, m_double = 0, m_triple = 0, m_busy = 0;

  press_decoder #(.GAP(GAP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .p(p), .single(single), .double(double),
    .triple(triple), .busy(busy), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W+3:0] dut_vec();
    return {single, double, triple, busy, evt_cnt};
  endfunction

  function automatic logic [CNT_W+3:0] mdl_vec();
    return {m_single, m_double, m_triple, m_busy, CNT_W'(m_cnt)};
  endfunction

  task automatic emit(input int n);
    m_single = (n == 1);
    m_double = (n == 2);
    m_triple = (n == 3);
    m_cnt    = (m_cnt + 1) % (1 << CNT_W);
  endtask

  task automatic model_reset();
    m_n = 0; m_cnt = 0; m_single = 0; m_double = 0; m_triple = 0; m_busy = 0;
  endtask

  // Drive one cycle of p, advance past the edge, and update the model.
  task automatic step(input logic pv);
    p = pv;
    @(posedge clk);
    #1;
    m_single = 0; m_double = 0; m_triple = 0;
    if (m_n == 0) begin
      if (pv) begin m_n = 1; m_last = m_t; end
    end else if (pv) begin
      m_n++;
      if (m_n == MAXN) begin emit(m_n); m_n = 0; end
      else m_last = m_t;
    end else if (m_t - m_last == GAP) begin
      emit(m_n); m_n = 0;
    end
    m_t++;
    m_busy = (m_n != 0);
    p = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0; p = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    if (dut_vec() !== '0) begin
      errors++; $display("FAIL reset_vals got=%b exp=0", dut_vec());
    end
    checks++;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b0);
  endtask

  task automatic test_single();
    int seen = 0, at = -1;
    step(1'b1);
    for (int i = 1; i <= GAP + 3; i++) begin
      step(1'b0);
      if (single) begin seen++; at = i; end
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL single cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
      end
      checks++;
    end
    if (seen != 1 || at != GAP) begin
      errors++; $display("FAIL single_when got=%0d/%0d exp=1/%0d", seen, at, GAP);
    end
    checks++;
  endtask

  task automatic test_double(input int k);
    int dbl = 0, sgl = 0;
    step(1'b1);
    for (int i = 1; i <= GAP + 3; i++) begin
      step(i == k);
      dbl += double; sgl += single;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL double_k%0d cyc=%0d got=%b exp=%b", k, i, dut_vec(), mdl_vec());
      end
      checks++;
    end
    if (sgl != 0 || dbl != ((MAXN == 2) ? 1 : 1)) begin
      errors++; $display("FAIL double_cnt_k%0d got=s%0d/d%0d exp=s0/d1", k, sgl, dbl);
    end
    checks++;
  endtask

  task automatic test_window_edge();
    test_double(GAP);
    step(1'b1);
    for (int i = 1; i <= 2 * GAP + 3; i++) begin
      step(i == GAP + 1);
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL late_pulse cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
      end
      checks++;
      if (i == GAP && single !== 1'b1) begin
        errors++; $display("FAIL late_single got=%b exp=1", single);
      end
      if (i == GAP) checks++;
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1);
    for (int i = 1; i <= 3 * GAP; i++) begin
      step(i == 1 || i == 2 || i == 3);
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL back_to_back cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
      end
      checks++;
    end
  endtask

`ifdef PRESS_DECODER_TRIPLE_EN
  task automatic test_triple();
    int trp = 0, dbl_at = -1;
    step(1'b1);
    for (int i = 1; i <= GAP + 3; i++) begin
      step(i == 2 || i == 5);
      trp += triple;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL triple cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
      end
      checks++;
    end
    step(1'b1);
    for (int i = 1; i <= GAP + 5; i++) begin
      step(i == 2);
      if (double) dbl_at = i;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL triple_dbl cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
      end
      checks++;
    end
    if (trp != 1 || dbl_at != 2 + GAP) begin
      errors++; $display("FAIL triple_when got=t%0d/d@%0d exp=t1/d@%0d", trp, dbl_at, 2 + GAP);
    end
    checks++;
  endtask
`endif

  task automatic test_reset_mid();
    apply_reset();
    step(1'b1);
    for (int i = 1; i <= 3; i++) step(1'b0);
    rst = 1'b0;
    #1;
    if (dut_vec() !== '0) begin
      errors++; $display("FAIL reset_mid got=%b exp=0", dut_vec());
    end
    checks++;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < GAP + 4; i++) begin
      step(1'b0);
      if (dut_vec() !== '0) begin
        errors++; $display("FAIL reset_after cyc=%0d got=%b exp=0", i, dut_vec());
      end
      checks++;
    end
  endtask

  task automatic test_wrap();
    int seq [5] = '{1, 2, 3, 0, 1};
    apply_reset();
    for (int n = 0; n < 5; n++) begin
      step(1'b1);
      for (int i = 1; i <= GAP + 2; i++) step(1'b0);
      if (evt_cnt !== CNT_W'(seq[n])) begin
        errors++; $display("FAIL wrap n=%0d got=%0d exp=%0d", n, evt_cnt, seq[n]);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 4) == 0);
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL random cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_double(3);
    test_double(1);
    test_window_edge();
    test_back_to_back();
`ifdef PRESS_DECODER_TRIPLE_EN
    test_triple();
`endif
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
